iurt_escaping: RTL and testbench

//  Byte-stream escaping stage between the JTAG hub channel and the IURT controller.
//  - Downstream (hub -> controller): strips escape symbols and detects in-band reset requests.
//  - Upstream (controller -> hub): inserts an escape symbol before every data byte that

---
 rtl/iurt_pkg.sv | 20 ++
 rtl/iurt_escape_tx.sv | 68 ++++++
 rtl/iurt_escaping.sv | 100 ++++++++++
 tb/tb_iurt_escaping.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iurt_pkg.sv
// Shared definitions for the IURT escaping stage: symbol defaults and
// the downstream FSM state type.
package iurt_pkg;

    localparam logic [7:0] ESC_SYM_DEFAULT = 8'h55;
    localparam logic [7:0] RST_SYM_DEFAULT = 8'hEE;

    typedef enum logic {
        DN_IDLE = 1'b0,
        DN_ESC  = 1'b1
    } dn_state_t;

    // True when a byte must be prefixed by an escape symbol upstream.
    function automatic logic needs_escape(input logic [7:0] b,
                                          input logic [7:0] esc_sym,
                                          input logic [7:0] rst_sym);
        return (b == esc_sym) || (b == rst_sym);
    endfunction

endpackage

// File: rtl/iurt_escape_tx.sv
// Upstream escape insertion: a one-byte buffer plus a pending escape flag.
// Handshake: a byte is taken when i_valid is high in a ce cycle; o_ready only
// advertises that the buffer is empty and the hub can accept. o_valid is a
// one-cycle pulse (held across ce-low cycles) and is never raised two cycles
// in a row.
module iurt_escape_tx
    import iurt_pkg::*;
#(
    parameter logic [7:0] ESCAPE_SYMBOL = ESC_SYM_DEFAULT,
    parameter logic [7:0] RESET_SYMBOL  = RST_SYM_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    input  logic       i_hub_ready,
    output logic       o_valid,
    output logic [7:0] o_data
);

    logic       r_esc_pending;
    logic       r_byte_pending;
    logic [7:0] r_byte;
    logic       r_valid;
    logic [7:0] r_data;
    logic       w_empty;
    logic       w_emit;

    assign w_empty = ~r_esc_pending & ~r_byte_pending;
    assign w_emit  = i_hub_ready & ~r_valid & ~w_empty;
    assign o_ready = i_hub_ready & w_empty;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Capture into the empty buffer, then emit escape first and the byte second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_esc_pending  <= 1'b0;
            r_byte_pending <= 1'b0;
            r_byte         <= 8'h00;
            r_valid        <= 1'b0;
            r_data         <= 8'h00;
        end else if (ce) begin
            r_valid <= 1'b0;
            if (i_valid && w_empty) begin
                r_byte         <= i_data;
                r_byte_pending <= 1'b1;
                r_esc_pending  <= needs_escape(i_data, ESCAPE_SYMBOL, RESET_SYMBOL);
            end else if (w_emit) begin
                r_valid <= 1'b1;
                if (r_esc_pending) begin
                    r_data        <= ESCAPE_SYMBOL;
                    r_esc_pending <= 1'b0;
                end else begin
                    r_data         <= r_byte;
                    r_byte_pending <= 1'b0;
                end
            end
        end
    end

    // A byte offered while the buffer is still occupied is dropped.
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(ce && i_valid && !w_empty));

endmodule

// File: rtl/iurt_escaping.sv
// Escaping stage between the JTAG hub and the IURT controller. Downstream
// strips escapes and turns unescaped reset symbols into a ctl_rst pulse;
// upstream inserts escapes in front of special bytes.
module iurt_escaping
    import iurt_pkg::*;
#(
    parameter logic [7:0] ESCAPE_SYMBOL = ESC_SYM_DEFAULT,
    parameter logic [7:0] RESET_SYMBOL  = RST_SYM_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    output logic       hub_dn_ready,
    input  logic       hub_dn_valid,
    input  logic [7:0] hub_dn_data,
    input  logic       hub_up_ready,
    output logic       hub_up_valid,
    output logic [7:0] hub_up_data,
    input  logic       ctl_dn_ready,
    output logic       ctl_dn_valid,
    output logic [7:0] ctl_dn_data,
    output logic       ctl_up_ready,
    input  logic       ctl_up_valid,
    input  logic [7:0] ctl_up_data,
    output logic       ctl_rst
);

    dn_state_t  r_dn_state;
    dn_state_t  w_dn_state_nxt;
    logic       r_dn_valid;
    logic [7:0] r_dn_data;
    logic       r_rst;
    logic       w_dn_valid_nxt;
    logic [7:0] w_dn_data_nxt;
    logic       w_rst_nxt;

    assign hub_dn_ready = ctl_dn_ready;
    assign ctl_dn_valid = r_dn_valid;
    assign ctl_dn_data  = r_dn_data;
    assign ctl_rst      = r_rst;

    // Downstream next state: escape prefix, reset request, or literal byte.
    always_comb begin
        w_dn_state_nxt = r_dn_state;
        w_dn_valid_nxt = 1'b0;
        w_dn_data_nxt  = r_dn_data;
        w_rst_nxt      = 1'b0;
        if (hub_dn_valid) begin
            case (r_dn_state)
                DN_IDLE: begin
                    if (hub_dn_data == ESCAPE_SYMBOL) begin
                        w_dn_state_nxt = DN_ESC;
                    end else if (hub_dn_data == RESET_SYMBOL) begin
                        w_rst_nxt = 1'b1;
                    end else begin
                        w_dn_valid_nxt = 1'b1;
                        w_dn_data_nxt  = hub_dn_data;
                    end
                end
                DN_ESC: begin
                    w_dn_valid_nxt = 1'b1;
                    w_dn_data_nxt  = hub_dn_data;
                    w_dn_state_nxt = DN_IDLE;
                end
                default: w_dn_state_nxt = DN_IDLE;
            endcase
        end
    end

    // Downstream registers; everything freezes while ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dn_state <= DN_IDLE;
            r_dn_valid <= 1'b0;
            r_dn_data  <= 8'h00;
            r_rst      <= 1'b0;
        end else if (ce) begin
            r_dn_state <= w_dn_state_nxt;
            r_dn_valid <= w_dn_valid_nxt;
            r_dn_data  <= w_dn_data_nxt;
            r_rst      <= w_rst_nxt;
        end
    end

    iurt_escape_tx #(
        .ESCAPE_SYMBOL (ESCAPE_SYMBOL),
        .RESET_SYMBOL  (RESET_SYMBOL)
    ) u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .i_valid     (ctl_up_valid),
        .i_data      (ctl_up_data),
        .o_ready     (ctl_up_ready),
        .i_hub_ready (hub_up_ready),
        .o_valid     (hub_up_valid),
        .o_data      (hub_up_data)
    );

endmodule

// File: tb/tb_iurt_escaping.sv
module tb_iurt_escaping;

    localparam logic [7:0] ESC = 8'h55;
    localparam logic [7:0] RST = 8'hEE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b1;
    logic       hub_dn_ready;
    logic       hub_dn_valid = 1'b0;
    logic [7:0] hub_dn_data = 8'h00;
    logic       hub_up_ready = 1'b1;
    logic       hub_up_valid;
    logic [7:0] hub_up_data;
    logic       ctl_dn_ready = 1'b1;
    logic       ctl_dn_valid;
    logic [7:0] ctl_dn_data;
    logic       ctl_up_ready;
    logic       ctl_up_valid = 1'b0;
    logic [7:0] ctl_up_data = 8'h00;
    logic       ctl_rst;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_dn[$];
    logic [7:0] act_dn[$];
    logic [7:0] exp_up[$];
    logic [7:0] act_up[$];
    int exp_rst;
    int act_rst;
    bit m_esc;

    iurt_escaping dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hub_dn_ready(hub_dn_ready), .hub_dn_valid(hub_dn_valid), .hub_dn_data(hub_dn_data),
        .hub_up_ready(hub_up_ready), .hub_up_valid(hub_up_valid), .hub_up_data(hub_up_data),
        .ctl_dn_ready(ctl_dn_ready), .ctl_dn_valid(ctl_dn_valid), .ctl_dn_data(ctl_dn_data),
        .ctl_up_ready(ctl_up_ready), .ctl_up_valid(ctl_up_valid), .ctl_up_data(ctl_up_data),
        .ctl_rst(ctl_rst)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // output monitor: a pulse is consumed in a cycle where ce is high
    always @(negedge clk) begin
        if (rst_n && ce) begin
            if (ctl_dn_valid) act_dn.push_back(ctl_dn_data);
            if (hub_up_valid) act_up.push_back(hub_up_data);
            if (ctl_rst) act_rst++;
        end
    end

    // reference model: downstream unescaping of a byte stream
    task automatic model_dn(input logic [7:0] b);
        if (m_esc) begin
            exp_dn.push_back(b);
            m_esc = 1'b0;
        end else if (b == ESC) begin
            m_esc = 1'b1;
        end else if (b == RST) begin
            exp_rst++;
        end else begin
            exp_dn.push_back(b);
        end
    endtask

    // reference model: upstream escaping of a byte
    task automatic model_up(input logic [7:0] b);
        if (b == ESC || b == RST) exp_up.push_back(ESC);
        exp_up.push_back(b);
    endtask

    task automatic clear_sb();
        exp_dn.delete(); act_dn.delete();
        exp_up.delete(); act_up.delete();
        exp_rst = 0; act_rst = 0;
    endtask

    // driver: one downstream byte, with ce high
    task automatic send_dn(input logic [7:0] b);
        @(posedge clk); #1;
        hub_dn_valid = 1'b1;
        hub_dn_data  = b;
        model_dn(b);
        @(posedge clk); #1;
        hub_dn_valid = 1'b0;
    endtask

    // driver: one upstream byte, caller ensures the buffer is empty
    task automatic send_up(input logic [7:0] b);
        @(posedge clk); #1;
        ctl_up_valid = 1'b1;
        ctl_up_data  = b;
        model_up(b);
        @(posedge clk); #1;
        ctl_up_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ctl_dn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dn_valid got %b want 0", ctl_dn_valid); end
        n_checks++; if (ctl_dn_data !== 8'h00) begin n_fail++; $display("FAIL reset_dn_data got %h want 00", ctl_dn_data); end
        n_checks++; if (hub_up_valid !== 1'b0) begin n_fail++; $display("FAIL reset_up_valid got %b want 0", hub_up_valid); end
        n_checks++; if (hub_up_data !== 8'h00) begin n_fail++; $display("FAIL reset_up_data got %h want 00", hub_up_data); end
        n_checks++; if (ctl_rst !== 1'b0) begin n_fail++; $display("FAIL reset_ctl_rst got %b want 0", ctl_rst); end
        rst_n = 1'b1;
        m_esc = 1'b0;
        #1;
        n_checks++; if (ctl_up_ready !== 1'b1) begin n_fail++; $display("FAIL reset_up_ready got %b want 1", ctl_up_ready); end
        ctl_dn_ready = 1'b0; #1;
        n_checks++; if (hub_dn_ready !== 1'b0) begin n_fail++; $display("FAIL dn_ready_pass0 got %b want 0", hub_dn_ready); end
        ctl_dn_ready = 1'b1; #1;
        n_checks++; if (hub_dn_ready !== 1'b1) begin n_fail++; $display("FAIL dn_ready_pass1 got %b want 1", hub_dn_ready); end
    endtask

    task automatic test_dn_seq();
        logic [7:0] seq [6] = '{8'h41, 8'h55, 8'h55, 8'h55, 8'hEE, 8'h42};
        clear_sb();
        foreach (seq[i]) send_dn(seq[i]);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (act_dn.size() !== exp_dn.size()) begin n_fail++; $display("FAIL dn_seq_count got %0d want %0d", act_dn.size(), exp_dn.size()); end
        for (int i = 0; i < exp_dn.size() && i < act_dn.size(); i++) begin
            n_checks++; if (act_dn[i] !== exp_dn[i]) begin n_fail++; $display("FAIL dn_seq_byte%0d got %h want %h", i, act_dn[i], exp_dn[i]); end
        end
        n_checks++; if (act_rst !== 0) begin n_fail++; $display("FAIL dn_seq_rst got %0d want 0", act_rst); end
    endtask

    task automatic test_rst_symbol();
        int hi_cycles;
        clear_sb();
        hi_cycles = 0;
        send_dn(RST);
        repeat (4) begin
            @(negedge clk);
            if (ctl_rst) hi_cycles++;
        end
        n_checks++; if (hi_cycles !== exp_rst) begin n_fail++; $display("FAIL rst_pulse_width got %0d want %0d", hi_cycles, exp_rst); end
        n_checks++; if (act_dn.size() !== 0) begin n_fail++; $display("FAIL rst_no_data got %0d want 0", act_dn.size()); end
    endtask

    task automatic test_up_escape();
        int seen;
        bit ready_err;
        clear_sb();
        hub_up_ready = 1'b1;
        seen = 0;
        ready_err = 1'b0;
        send_up(ESC);
        for (int c = 0; c < 20 && seen < 2; c++) begin
            #1;
            if (hub_up_valid) seen++;
            if (seen < 2 && ctl_up_ready) ready_err = 1'b1;
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ready_err !== 1'b0) begin n_fail++; $display("FAIL up_esc_ready_low got %b want 0", ready_err); end
        n_checks++; if (act_up.size() !== exp_up.size()) begin n_fail++; $display("FAIL up_esc_count got %0d want %0d", act_up.size(), exp_up.size()); end
        for (int i = 0; i < exp_up.size() && i < act_up.size(); i++) begin
            n_checks++; if (act_up[i] !== exp_up[i]) begin n_fail++; $display("FAIL up_esc_byte%0d got %h want %h", i, act_up[i], exp_up[i]); end
        end
    endtask

    task automatic test_up_stall();
        int early;
        clear_sb();
        early = 0;
        hub_up_ready = 1'b1;
        @(posedge clk); #1;
        ctl_up_valid = 1'b1;
        ctl_up_data  = 8'h33;
        model_up(8'h33);
        @(posedge clk); #1;
        ctl_up_valid = 1'b0;
        hub_up_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (hub_up_valid) early++;
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL up_stall_early got %0d want 0", early); end
        @(posedge clk); #1;
        hub_up_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (act_up.size() !== 1) begin n_fail++; $display("FAIL up_stall_count got %0d want 1", act_up.size()); end
        if (act_up.size() > 0) begin
            n_checks++; if (act_up[0] !== exp_up[0]) begin n_fail++; $display("FAIL up_stall_byte got %h want %h", act_up[0], exp_up[0]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        hub_up_ready = 1'b1;
        @(posedge clk); #1;
        ctl_up_valid = 1'b1;
        ctl_up_data  = RST;
        @(posedge clk); #1;
        ctl_up_valid = 1'b0;
        hub_up_ready = 1'b0;
        send_dn(ESC);
        send_dn(8'h77);
        send_dn(ESC);
        @(posedge clk); #3;
        rst_n = 1'b0;
        hub_up_ready = 1'b1;
        #1;
        n_checks++; if (ctl_dn_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dn_valid got %b want 0", ctl_dn_valid); end
        n_checks++; if (ctl_dn_data !== 8'h00) begin n_fail++; $display("FAIL midrst_dn_data got %h want 00", ctl_dn_data); end
        n_checks++; if (hub_up_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_up_valid got %b want 0", hub_up_valid); end
        n_checks++; if (ctl_up_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_buffer_empty got %b want 1", ctl_up_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_sb();
        m_esc = 1'b0;
        send_dn(ESC);
        send_dn(8'h41);
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (act_dn.size() !== 1) begin n_fail++; $display("FAIL midrst_dn_count got %0d want 1", act_dn.size()); end
        if (act_dn.size() > 0) begin
            n_checks++; if (act_dn[0] !== 8'h41) begin n_fail++; $display("FAIL midrst_dn_byte got %h want 41", act_dn[0]); end
        end
        n_checks++; if (act_up.size() !== 0) begin n_fail++; $display("FAIL midrst_up_discard got %0d want 0", act_up.size()); end
    endtask

    // randomised ce, downstream bytes, upstream bytes and hub_up_ready together
    task automatic run_random(input int n_dn, input int n_up, input bit fixed_seq);
        logic [7:0] dq[$];
        logic [7:0] uq[$];
        logic [7:0] seq [6] = '{8'h41, 8'h55, 8'h55, 8'h55, 8'hEE, 8'h42};
        logic [7:0] b;
        int sel;
        for (int i = 0; i < n_dn; i++) begin
            if (fixed_seq) b = seq[i % 6];
            else begin
                sel = $urandom_range(0, 3);
                b = (sel == 0) ? ESC : (sel == 1) ? RST : 8'($urandom_range(0, 255));
            end
            dq.push_back(b);
        end
        for (int i = 0; i < n_up; i++) begin
            sel = $urandom_range(0, 3);
            b = (sel == 0) ? ESC : (sel == 1) ? RST : 8'($urandom_range(0, 255));
            uq.push_back(b);
        end
        for (int c = 0; c < 3000 && (dq.size() > 0 || uq.size() > 0); c++) begin
            @(posedge clk); #1;
            hub_dn_valid = 1'b0;
            ctl_up_valid = 1'b0;
            ce = 1'($urandom_range(0, 1));
            hub_up_ready = fixed_seq ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (ce && dq.size() > 0 && $urandom_range(0, 1) == 1) begin
                hub_dn_valid = 1'b1;
                hub_dn_data  = dq.pop_front();
                model_dn(hub_dn_data);
            end
            if (ce && ctl_up_ready && uq.size() > 0 && $urandom_range(0, 1) == 1) begin
                ctl_up_valid = 1'b1;
                ctl_up_data  = uq.pop_front();
                model_up(ctl_up_data);
            end
        end
        @(posedge clk); #1;
        hub_dn_valid = 1'b0;
        ctl_up_valid = 1'b0;
        hub_up_ready = 1'b1;
        ce = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (dq.size() + uq.size() !== 0) begin n_fail++; $display("FAIL rand_stim_timeout left %0d want 0", dq.size() + uq.size()); end
    endtask

    task automatic test_ce_toggle();
        clear_sb();
        run_random(6, 0, 1'b1);
        n_checks++; if (act_dn.size() !== exp_dn.size()) begin n_fail++; $display("FAIL ce_dn_count got %0d want %0d", act_dn.size(), exp_dn.size()); end
        for (int i = 0; i < exp_dn.size() && i < act_dn.size(); i++) begin
            n_checks++; if (act_dn[i] !== exp_dn[i]) begin n_fail++; $display("FAIL ce_dn_byte%0d got %h want %h", i, act_dn[i], exp_dn[i]); end
        end
        n_checks++; if (act_rst !== 0) begin n_fail++; $display("FAIL ce_rst got %0d want 0", act_rst); end
    endtask

    task automatic test_random();
        clear_sb();
        run_random(60, 40, 1'b0);
        n_checks++; if (act_dn.size() !== exp_dn.size()) begin n_fail++; $display("FAIL rand_dn_count got %0d want %0d", act_dn.size(), exp_dn.size()); end
        for (int i = 0; i < exp_dn.size() && i < act_dn.size(); i++) begin
            n_checks++; if (act_dn[i] !== exp_dn[i]) begin n_fail++; $display("FAIL rand_dn_byte%0d got %h want %h", i, act_dn[i], exp_dn[i]); end
        end
        n_checks++; if (act_rst !== exp_rst) begin n_fail++; $display("FAIL rand_rst got %0d want %0d", act_rst, exp_rst); end
        n_checks++; if (act_up.size() !== exp_up.size()) begin n_fail++; $display("FAIL rand_up_count got %0d want %0d", act_up.size(), exp_up.size()); end
        for (int i = 0; i < exp_up.size() && i < act_up.size(); i++) begin
            n_checks++; if (act_up[i] !== exp_up[i]) begin n_fail++; $display("FAIL rand_up_byte%0d got %h want %h", i, act_up[i], exp_up[i]); end
        end
    endtask

    initial begin
        m_esc = 1'b0;
        clear_sb();
        test_reset();
        test_dn_seq();
        test_rst_symbol();
        test_up_escape();
        test_up_stall();
        test_reset_mid();
        test_ce_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
